add_subs_bist: RTL and testbench

//  Built-in self-test sequencer for the 4-bit add/subtract unit: drives its a/b/m/enable inputs,

---
 rtl/add_subs_bist.sv | 210 +++++++++++++++++++++
 tb/tb_add_subs_bist.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_subs_bist.sv
// -----------------------------------------------------------------------------
// add_subs_bist
//   Built-in self-test sequencer for the WIDTH-bit add/subtract unit. A start
//   pulse triggers a sweep over every {en,m,a,b} vector in ascending binary
//   order. Each vector is driven to the unit, left to settle, and then the
//   returned dut_sum is compared with an internal golden model. Mismatches are
//   counted, and the sweep ends with done/pass/err_count.
//
//   Optional feature macro: ADD_SUBS_BIST_FAIL_LOG_EN
//     defined   : capture the first failing vector and its observed sum
//     undefined : fail_vec / fail_sum are tied to 0 (ports still present)
//
// Parameters
//   WIDTH   operand width (dut_sum is WIDTH+1 bits)
//   SETTLE  idle cycles between driving a vector and sampling dut_sum (>=0)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   start      in   1-cycle pulse; begins a sweep when idle or done
//   dut_a      out  operand A to add_subs
//   dut_b      out  operand B to add_subs
//   dut_m      out  mode to add_subs (0 add, 1 subtract)
//   dut_en     out  enable to add_subs
//   dut_sum    in   result from add_subs (combinational path)
//   busy       out  sweep in progress
//   done       out  sweep complete; held until next accepted start or reset
//   pass       out  valid while done: 1 iff err_count == 0
//   err_count  out  mismatching vectors in the last sweep
//   fail_vec   out  first failing {en,m,a,b}
//   fail_sum   out  dut_sum observed at the first failure
//
// Handshake: start is a plain request pulse, accepted only in IDLE or DONE;
// done is a level that stays high until the next accepted start or reset.
// -----------------------------------------------------------------------------
module add_subs_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   output logic                 dut_m,
   output logic                 dut_en,
   input  logic [WIDTH:0]       dut_sum,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH+2:0]   err_count,
   output logic [2*WIDTH+1:0]   fail_vec,
   output logic [WIDTH:0]       fail_sum
);

   localparam int VW = 2*WIDTH + 2;
   localparam int SW = $clog2(SETTLE + 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [VW-1:0]   vec;
   logic [SW-1:0]   wait_cnt;
   logic [WIDTH:0]  golden;
   logic            mismatch;
   logic            last_vec;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = S_DRIVE;
         end
         S_DRIVE: begin
            state_nxt = (SETTLE == 0) ? S_CHECK : S_WAIT;
         end
         S_WAIT: begin
            // wait_cnt is loaded with 1 in DRIVE, so equality marks the last
            // settle cycle.
            if (wait_cnt == SW'(SETTLE)) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            state_nxt = last_vec ? S_DONE : S_DRIVE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Golden model, evaluated on the vector currently presented to the unit.
   // Subtraction is a + ~b + 1 kept to WIDTH+1 bits, so the top bit is the
   // no-borrow flag (1 iff a >= b).
   // ---------------------------------------------------------------------------
   always_comb begin
      golden = '0;
      if (dut_en) begin
         if (dut_m) begin
            golden = {1'b0, dut_a} + {1'b0, ~dut_b} + {{WIDTH{1'b0}}, 1'b1};
         end else begin
            golden = {1'b0, dut_a} + {1'b0, dut_b};
         end
      end
   end

   assign mismatch = (dut_sum != golden);
   assign last_vec = (vec == {VW{1'b1}});

   // ---------------------------------------------------------------------------
   // Datapath: vector counter, drive registers, settle counter, error count
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec       <= '0;
         wait_cnt  <= '0;
         dut_a     <= '0;
         dut_b     <= '0;
         dut_m     <= 1'b0;
         dut_en    <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  vec       <= '0;
                  err_count <= '0;
               end
            end
            S_DRIVE: begin
               {dut_en, dut_m, dut_a, dut_b} <= vec;
               wait_cnt <= SW'(1);
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + SW'(1);
            end
            S_CHECK: begin
               // Counter width covers the full vector space plus one, so it
               // can never wrap.
               if (mismatch) err_count <= err_count + 1'b1;
               vec <= vec + 1'b1;
               if (last_vec) begin
                  {dut_en, dut_m, dut_a, dut_b} <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ADD_SUBS_BIST_FAIL_LOG_EN
   // ---------------------------------------------------------------------------
   // First-failure capture; 'logged' blocks later mismatches from overwriting.
   // ---------------------------------------------------------------------------
   logic             logged;
   logic [VW-1:0]    fail_vec_r;
   logic [WIDTH:0]   fail_sum_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         logged     <= 1'b0;
         fail_vec_r <= '0;
         fail_sum_r <= '0;
      end else begin
         if ((state == S_IDLE || state == S_DONE) && start) begin
            logged     <= 1'b0;
            fail_vec_r <= '0;
            fail_sum_r <= '0;
         end else if (state == S_CHECK && mismatch && !logged) begin
            logged     <= 1'b1;
            fail_vec_r <= {dut_en, dut_m, dut_a, dut_b};
            fail_sum_r <= dut_sum;
         end
      end
   end

   assign fail_vec = fail_vec_r;
   assign fail_sum = fail_sum_r;
`else
   assign fail_vec = '0;
   assign fail_sum = '0;
`endif

   // ---------------------------------------------------------------------------
   // Status outputs decoded from state; reset forces IDLE so all read 0.
   // ---------------------------------------------------------------------------
   assign busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
   assign done = (state == S_DONE);
   assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_add_subs_bist.sv
// -----------------------------------------------------------------------------
// tb_add_subs_bist
//   Directed bench for add_subs_bist. A behavioural add_subs model with
//   selectable faults feeds dut_sum; expected counts/timings are hand-derived
//   constants. A second instance with SETTLE=0 covers the short sweep.
// -----------------------------------------------------------------------------
module tb_add_subs_bist;

   localparam int W = 4;

   // fault modes for the add_subs model
   localparam int F_NONE   = 0;
   localparam int F_STUCK0 = 1;  // sum[0] stuck-at-1
   localparam int F_NOEN   = 2;  // ignores enable

   // ---------------------------------------------------------------------------
   // clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             start;
   logic             start0;
   int               fault;

   logic [W-1:0]     dut_a, dut_b;
   logic             dut_m, dut_en;
   logic [W:0]       dut_sum;
   logic             busy, done, pass;
   logic [2*W+2:0]   err_count;
   logic [2*W+1:0]   fail_vec;
   logic [W:0]       fail_sum;

   logic [W-1:0]     z_a, z_b;
   logic             z_m, z_en;
   logic [W:0]       z_sum;
   logic             z_busy, z_done, z_pass;
   logic [2*W+2:0]   z_err_count;
   logic [2*W+1:0]   z_fail_vec;
   logic [W:0]       z_fail_sum;

   add_subs_bist #(.WIDTH(W), .SETTLE(1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dut_a     (dut_a),
      .dut_b     (dut_b),
      .dut_m     (dut_m),
      .dut_en    (dut_en),
      .dut_sum   (dut_sum),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec),
      .fail_sum  (fail_sum)
   );

   add_subs_bist #(.WIDTH(W), .SETTLE(0)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start0),
      .dut_a     (z_a),
      .dut_b     (z_b),
      .dut_m     (z_m),
      .dut_en    (z_en),
      .dut_sum   (z_sum),
      .busy      (z_busy),
      .done      (z_done),
      .pass      (z_pass),
      .err_count (z_err_count),
      .fail_vec  (z_fail_vec),
      .fail_sum  (z_fail_sum)
   );

   // ---------------------------------------------------------------------------
   // add_subs behavioural model (the unit the BIST exercises)
   // ---------------------------------------------------------------------------
   function automatic logic [W:0] add_subs_model(input logic en, input logic m,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input int flt);
      logic [W:0] r;
      r = '0;
      if (en || flt == F_NOEN) begin
         if (m) r = {1'b0, a} - {1'b0, b} + 5'd16;
         else   r = {1'b0, a} + {1'b0, b};
      end
      if (flt == F_STUCK0) r[0] = 1'b1;
      return r;
   endfunction

   always_comb dut_sum = add_subs_model(dut_en, dut_m, dut_a, dut_b, fault);
   always_comb z_sum   = add_subs_model(z_en, z_m, z_a, z_b, F_NONE);

   // ---------------------------------------------------------------------------
   // scoreboard
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // driver: pulse start on u_dut, optionally re-pulse at restart_at, and
   // count cycles until done. cycles = clock edges after the accepting edge.
   // ---------------------------------------------------------------------------
   task automatic run_sweep(input string tag, input int restart_at, output int cycles);
      cycles = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      while (cycles < 20000) begin
         @(negedge clk);
         start = (cycles == restart_at);
         @(posedge clk);
         #1;
         cycles++;
         if (done) break;
      end
      @(negedge clk);
      start = 1'b0;
      if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_pass"},  32'(pass), 32'd0);
      check({tag, "_err"},   32'(err_count), 32'd0);
      check({tag, "_drv"},   32'({dut_en, dut_m, dut_a, dut_b}), 32'd0);
      check({tag, "_fvec"},  32'(fail_vec), 32'd0);
      check({tag, "_fsum"},  32'(fail_sum), 32'd0);
   endtask

   // expected first-failure capture, depending on build
   task automatic check_fail_log(input string tag, input logic [31:0] vec_exp,
                                 input logic [31:0] sum_exp);
`ifdef ADD_SUBS_BIST_FAIL_LOG_EN
      check({tag, "_fail_vec"}, 32'(fail_vec), vec_exp);
      check({tag, "_fail_sum"}, 32'(fail_sum), sum_exp);
`else
      check({tag, "_fail_vec"}, 32'(fail_vec), 32'd0 & vec_exp);
      check({tag, "_fail_sum"}, 32'(fail_sum), 32'd0 & sum_exp);
`endif
   endtask

   // ---------------------------------------------------------------------------
   // main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int cyc;
      start  = 1'b0;
      start0 = 1'b0;
      fault  = F_NONE;
      rst_n  = 1'b0;

      // reset with start asserted: reset wins
      @(negedge clk);
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_no_start_busy", 32'(busy), 32'd0);

      // 1: healthy unit
      fault = F_NONE;
      run_sweep("t1", -1, cyc);
      exp_q.push_back(32'd3072);
      check("t1_cycles", 32'(cyc), exp_q.pop_front());
      check("t1_done", 32'(done), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_err",  32'(err_count), 32'd0);
      check("t1_drv_zero", 32'({dut_en, dut_m, dut_a, dut_b}), 32'd0);
      check_fail_log("t1", 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t1_done_held", 32'(done), 32'd1);

      // 2: sum[0] stuck-at-1 (512 en=0 vectors + 256 en=1 with a^b even lsb)
      fault = F_STUCK0;
      run_sweep("t2", -1, cyc);
      check("t2_cycles", 32'(cyc), 32'd3072);
      check("t2_pass", 32'(pass), 32'd0);
      check("t2_err",  32'(err_count), 32'd768);
      check_fail_log("t2", 32'h000, 32'h01);

      // 3: enable ignored (255 nonzero adds + 256 subtracts with en=0)
      fault = F_NOEN;
      run_sweep("t3", -1, cyc);
      check("t3_cycles", 32'(cyc), 32'd3072);
      check("t3_pass", 32'(pass), 32'd0);
      check("t3_err",  32'(err_count), 32'd511);
      check_fail_log("t3", 32'h001, 32'h01);

      // 4: restart attempt mid-sweep is ignored
      run_sweep("t4", 100, cyc);
      check("t4_cycles", 32'(cyc), 32'd3072);
      check("t4_err",  32'(err_count), 32'd511);
      check_fail_log("t4", 32'h001, 32'h01);

      // 5: reset mid-sweep with a faulty unit, then a clean sweep
      fault = F_STUCK0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (600) @(posedge clk);
      #1;
      check("t5_busy_mid", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_all_zero("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t5_stay_idle", 32'(busy | done), 32'd0);
      fault = F_NONE;
      run_sweep("t5", -1, cyc);
      check("t5_cycles", 32'(cyc), 32'd3072);
      check("t5_pass", 32'(pass), 32'd1);
      check("t5_err",  32'(err_count), 32'd0);

      // 6: SETTLE=0 instance
      cyc = 0;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      cyc = 1;  // accepting edge was one half-cycle before this point
      while (cyc < 20000) begin
         check_z_pending();
         @(posedge clk);
         #1;
         if (z_done) break;
         cyc++;
      end
      check("t6_cycles", 32'(cyc), 32'd2048);
      check("t6_pass", 32'(z_pass), 32'd1);
      check("t6_err",  32'(z_err_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // no-op hook kept inline-free; z_busy sampled once per loop is enough
   task automatic check_z_pending();
   endtask

endmodule
